// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: opcode constants, the canonical NOP and
// the {instr, pc} record carried from fetch to decode.
package riscv_pkg;

  localparam int FETCH_AW = 32;

  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]          instr;
    logic [FETCH_AW-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {instr, pc} entries; flush empties it and
// overrides any same-cycle push or pop.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           wdata,
  output fetch_entry_t           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t   mem_q [DEPTH];
  logic [PW-1:0]  wr_q, rd_q;
  logic [PW:0]    cnt_q;
  logic           push_eff, pop_eff;

  assign push_eff = push & ~flush;
  assign pop_eff  = pop & ~flush;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_eff) wr_q <= wr_q + 1'b1;
      if (pop_eff)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (PW+1)'(push_eff) - (PW+1)'(pop_eff);
    end
  end

  // Storage holds data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (rst_n && push_eff) mem_q[wr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush) assert (!(pop && cnt_q == '0)) else $error("fetch_fifo underflow");
  end

  assign rdata = mem_q[rd_q];
  assign count = cnt_q;
  assign full  = (cnt_q == (PW+1)'(DEPTH));
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: credit-limited imem requests, in-order response
// buffering, valid/ready delivery to decode and branch redirect with flush.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [31:0]           imem_rsp_data,
  input  logic                  pc_src,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [31:0]           instr,
  output logic [ADDR_WIDTH-1:0] instr_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, target;
  logic [CW-1:0]         out_q, out_d, drop_q, drop_d, out_after_rsp, fifo_count;
  logic [CW:0]           credit_used;
  logic                  req_fire, push, pop, drop_rsp, fifo_full, fifo_empty;
  fetch_entry_t          wentry, rentry;

  assign target        = {branch_target[ADDR_WIDTH-1:2], 2'b00};
  assign credit_used   = {1'b0, out_q} + {1'b0, fifo_count};
  assign imem_req_valid = rst_n & ~pc_src & (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr = fetch_pc_q;
  assign req_fire      = imem_req_valid & imem_req_ready;
  assign drop_rsp      = imem_rsp_valid & (drop_q != '0);
  assign push          = imem_rsp_valid & (drop_q == '0) & ~pc_src;
  assign pop           = instr_valid & instr_ready & ~pc_src;
  assign out_after_rsp = out_q - CW'(imem_rsp_valid);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    out_d      = out_after_rsp;
    drop_d     = drop_q;
    if (pc_src) begin
      // Everything still in flight after this cycle's response is wrong-path.
      fetch_pc_d = target;
      rsp_pc_d   = target;
      drop_d     = out_after_rsp;
    end else begin
      out_d = out_after_rsp + CW'(req_fire);
      if (req_fire) fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
      if (drop_rsp) drop_d = drop_q - 1'b1;
      if (push)     rsp_pc_d = rsp_pc_q + ADDR_WIDTH'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && fifo_full && !pop)) else $error("fetch buffer overflow");
      assert (out_q <= CW'(DEPTH) && drop_q <= CW'(DEPTH)) else $error("counter exceeds DEPTH");
    end
  end

  always_comb begin
    wentry       = '0;
    wentry.instr = imem_rsp_data;
    wentry.pc    = FETCH_AW'(rsp_pc_q);
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (pc_src),
    .wdata (wentry),
    .rdata (rentry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign instr_valid = ~fifo_empty;
  assign instr       = fifo_empty ? NOP_INSTR : rentry.instr;
  assign instr_pc    = fifo_empty ? RESET_PC : rentry.pc[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: random imem/decode environment checked every cycle
// against a queue-based model, plus directed scenarios with literal expectations.
module tb_fetch_unit;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        pc_src = 1'b0;
  logic [31:0] branch_target = '0;
  logic        instr_valid, instr_ready = 1'b0;
  logic [31:0] instr, instr_pc;

  fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .pc_src(pc_src), .branch_target(branch_target),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0013;
  endfunction

  // Stimulus for the next step
  bit          rst_v = 0, psrc_v = 0, irdy_v = 0, qrdy_v = 0;
  logic [31:0] tgt_v = '0;
  int          lat_lo = 1, lat_hi = 1;

  // Memory environment: in-order pending requests
  typedef struct { logic [31:0] addr; int due; } req_t;
  req_t pend[$];
  int   cyc = 0;

  // Behavioural model
  typedef struct { logic [31:0] ins; logic [31:0] pc; } ent_t;
  ent_t        mq[$];
  bit          known = 0, fresh = 0;
  int          infl = 0, drop = 0;
  logic [31:0] fpc = '0, rpc = '0;

  // Observations from the latest step
  logic        obs_rv, obs_iv;
  logic [31:0] obs_addr, obs_instr, obs_pc;

  task automatic step();
    bit   exp_rv, rsp;
    ent_t e;
    @(negedge clk);
    rsp = 0;
    imem_rsp_valid = 1'b0;
    if (!rst_v) pend.delete();
    else if (pend.size() > 0 && pend[0].due <= cyc) begin
      rsp = 1;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end
    rst_n = rst_v; pc_src = psrc_v; branch_target = tgt_v;
    instr_ready = irdy_v; imem_req_ready = qrdy_v;
    #1;
    obs_rv = imem_req_valid; obs_addr = imem_req_addr; obs_iv = instr_valid;
    obs_instr = instr; obs_pc = instr_pc;

    exp_rv = rst_v && !psrc_v && known && (infl + mq.size() < DEPTH);
    if (known || !rst_v) check("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
    if (exp_rv) check("req_addr", imem_req_addr, fpc);
    if (known) begin
      check("instr_valid", {31'b0, instr_valid}, {31'b0, mq.size() > 0});
      if (mq.size() > 0) begin
        check("instr", instr, mq[0].ins);
        check("instr_pc", instr_pc, mq[0].pc);
      end else if (fresh) begin
        check("reset_instr", instr, NOP);
        check("reset_pc", instr_pc, 32'h0);
      end
    end

    if (rst_v && imem_req_valid && imem_req_ready)
      pend.push_back('{addr: imem_req_addr, due: cyc + $urandom_range(lat_hi, lat_lo)});

    if (!rst_v) begin
      known = 1; fresh = 1; infl = 0; drop = 0; fpc = 0; rpc = 0; mq.delete();
    end else if (known) begin
      if (psrc_v) begin
        infl = infl - int'(rsp);
        drop = infl;
        mq.delete();
        fpc = {tgt_v[31:2], 2'b00};
        rpc = fpc;
        fresh = 0;
      end else begin
        if (mq.size() > 0 && irdy_v) void'(mq.pop_front());
        if (rsp) begin
          if (drop > 0) drop--;
          else begin
            e.ins = mem_word(rpc); e.pc = rpc;
            mq.push_back(e);
            rpc += 4;
            fresh = 0;
          end
        end
        infl = infl + int'(exp_rv && qrdy_v) - int'(rsp);
        if (exp_rv && qrdy_v) fpc += 4;
      end
    end
    cyc++;
  endtask

  initial begin
    logic [31:0] held;
    bit found;

    // Reset held for three cycles
    rst_v = 0; irdy_v = 1; qrdy_v = 1; lat_lo = 1; lat_hi = 1;
    repeat (3) begin
      step();
      check("t1_rst_req_valid", {31'b0, obs_rv}, 32'h0);
    end
    rst_v = 1;
    step();
    check("t1_first_req_valid", {31'b0, obs_rv}, 32'h1);
    check("t1_first_addr", obs_addr, 32'h0);
    check("t1_iv_after_rst", {31'b0, obs_iv}, 32'h0);
    step();
    check("t1_second_addr", obs_addr, 32'h4);

    // Streaming at latency 1: pcs 0,4,8,C on consecutive cycles
    for (int i = 0; i < 4; i++) begin
      step();
      check("t2_iv", {31'b0, obs_iv}, 32'h1);
      check("t2_pc", obs_pc, 32'(i * 4));
      check("t2_instr", obs_instr, mem_word(32'(i * 4)));
    end

    // Backpressure: buffer fills, requests stop, head held
    irdy_v = 0;
    repeat (8) step();
    held = obs_pc;
    repeat (4) begin
      step();
      check("t3_req_stopped", {31'b0, obs_rv}, 32'h0);
      check("t3_head_held", obs_pc, held);
    end
    irdy_v = 1;
    repeat (6) step();

    // Redirect with responses in flight
    lat_lo = 2; lat_hi = 2;
    repeat (6) step();
    psrc_v = 1; tgt_v = 32'h40;
    step();
    psrc_v = 0;
    step();
    check("t4_iv_cleared", {31'b0, obs_iv}, 32'h0);
    check("t4_req_addr", obs_addr, 32'h40);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (obs_iv) begin
        found = 1;
        check("t4_first_pc", obs_pc, 32'h40);
      end
    end
    check("t4_seen", {31'b0, found}, 32'h1);

    // Redirect coinciding with a response and a pop, unaligned target
    lat_lo = 1; lat_hi = 1;
    repeat (6) step();
    psrc_v = 1; tgt_v = 32'h43;
    step();
    psrc_v = 0;
    step();
    check("t5_iv_cleared", {31'b0, obs_iv}, 32'h0);
    check("t5_req_addr", obs_addr, 32'h40);

    // Address wrap, then mid-stream reset
    repeat (4) step();
    psrc_v = 1; tgt_v = 32'hFFFF_FFFC;
    step();
    psrc_v = 0;
    step();
    check("t6_wrap_addr0", obs_addr, 32'hFFFF_FFFC);
    step();
    check("t6_wrap_valid", {31'b0, obs_rv}, 32'h1);
    check("t6_wrap_addr1", obs_addr, 32'h0);
    repeat (3) step();
    rst_v = 0;
    step();
    rst_v = 1;
    step();
    check("t6_rst_iv", {31'b0, obs_iv}, 32'h0);
    check("t6_rst_instr", obs_instr, NOP);
    check("t6_rst_pc", obs_pc, 32'h0);
    check("t6_rst_addr", obs_addr, 32'h0);

    // Randomized traffic
    for (int blk = 0; blk < 6; blk++) begin
      lat_lo = 1; lat_hi = $urandom_range(1, 5);
      for (int i = 0; i < 500; i++) begin
        rst_v  = ($urandom_range(0, 199) != 0);
        psrc_v = ($urandom_range(0, 15) == 0);
        tgt_v  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
        irdy_v = ($urandom_range(0, 9) < 7);
        qrdy_v = ($urandom_range(0, 9) < 7);
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
